ifft_twiddle_sequencer: RTL and testbench
=========================================

Name: ifft_twiddle_sequencer

Overview:
- Sequences twiddle-factor reads for the radix-2 IFFT engine.
- Walks stage by stage and butterfly by butterfly, drives the imaginary twiddle ROM address, and absorbs the ROM's 1-cycle registered read latency.
- Presents an aligned twiddle/stage/butterfly tag stream to the butterfly datapath with a valid/ready handshake.
- Sits between the IFFT top-level control (start/done) and the twiddle ROM plus butterfly unit.

Parameters:
- NUM_STAGES, 7, number of IFFT stages sequenced per frame.
- BFLY_PER_STAGE, 8, butterflies issued per stage (power of 2).
- WORDS_PER_STAGE, 4, ROM words reserved per stage (power of 2, ≤ BFLY_PER_STAGE).
- ADDR_W, 5, ROM address width.
- DATA_W, 16, twiddle word width (signed Q8: 0x0100 = 1.0).

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle pulse; begins a frame when IDLE.
- abort, input, 1, synchronous frame cancel.
- busy, output, 1, high from accepted start until done/abort.
- done, output, 1, one-cycle pulse after last twiddle accepted.
- rom_addr, output, ADDR_W, address to twiddle ROM (registered-read ROM).
- rom_data, input, DATA_W, ROM output, valid 1 cycle after rom_addr.
- tw_data, output, DATA_W, registered twiddle to datapath.
- tw_stage, output, 3, stage index of tw_data.
- tw_bfly, output, 3, butterfly index of tw_data.
- tw_valid, output, 1, tw_data/tags valid.
- tw_ready, input, 1, datapath accepts when tw_valid & tw_ready.
- stage_done, output, 1, one-cycle pulse when last butterfly of a stage is accepted.

Behaviour:
- Reset (rst_n low, async): state=IDLE; busy, done, tw_valid, stage_done = 0; rom_addr, tw_data, tw_stage, tw_bfly = 0; counters = 0.
- FSM states:
  - IDLE: start → RUN; clear stage/bfly counters.
  - RUN: issue one address per cycle while not stalled; after issuing (NUM_STAGES-1, BFLY_PER_STAGE-1) → DRAIN.
  - DRAIN: wait for the in-flight pipeline to empty; → DONE.
  - DONE: done=1 for one cycle; → IDLE.
- Address rule: rom_addr = stage*WORDS_PER_STAGE + (bfly mod WORDS_PER_STAGE), truncated to ADDR_W.
- Issue order: bfly increments 0..BFLY_PER_STAGE-1, then wraps to 0 and stage increments.
- Pipeline:
  - Address registered at issue, cycle t.
  - rom_data valid at t+1; a valid/tag shift register p1 tracks it.
  - tw_data captured at the t+1 edge, so tw_valid is high at t+2.
  - Throughput 1/cycle. Start-to-first tw_valid = 3 cycles (start sampled at t0, addr 0 at t1, tw_valid at t3).
- Stall: when tw_valid & !tw_ready, freeze rom_addr, counters, p1 and output registers. The ROM keeps re-reading the held address, so rom_data stays consistent. No word is dropped or duplicated.
- stage_done: asserts in the cycle the tw_bfly=BFLY_PER_STAGE-1 beat is accepted.
- done: asserts the cycle after the final beat (stage NUM_STAGES-1, bfly BFLY_PER_STAGE-1) is accepted; busy falls in the same cycle.
- start while busy: ignored.
- start in the DONE cycle: ignored; it must be re-pulsed in IDLE.
- abort (any non-IDLE state): next cycle state=IDLE, tw_valid=0, p1 cleared, busy=0, no done pulse. Abort has priority over stall and start.
- Async reset mid-frame: identical to the reset values above. No residual valid after reset release.
- tw_stage/tw_bfly hold their last values when tw_valid=0.

Test Plan:
1. Reset, start pulse, tw_ready=1 → rom_addr sequence 0,1,2,3,0,1,2,3,4,5,6,7,4,…; tw_valid first at start+3; 56 beats contiguous; stage_done ×7; done pulse once; busy low after.
2. Start with a ROM model holding the imaginary twiddle table, check tags → beat (stage 5, bfly 1) addr 21, tw_data=0x00FE; (stage 2, bfly 1) addr 9, tw_data=0x00B5; (stage 6, bfly 3) addr 27, tw_data=0x00CD.
3. Random tw_ready toggling (~50%) → same 56-beat data/tag sequence as scenario 1 with no drops or duplicates; rom_addr stable during every stall cycle.
4. abort at beat 20 with tw_ready=1 → tw_valid=0 and busy=0 the next cycle; no done; a new start restarts from addr 0.
5. Extra start pulses during RUN and during the DONE cycle → ignored; exactly 56 beats and one done.
6. rst_n asserted mid-frame (asynchronously, between edges) → all outputs 0 immediately; after release, idle until start.

Source files
------------

// File: rtl/ifft_twiddle_sequencer.sv
// Twiddle-factor read sequencer for the radix-2 IFFT: walks stage/butterfly, drives the
// registered-read twiddle ROM and presents an aligned twiddle/tag stream with valid/ready.
module ifft_twiddle_sequencer #(
  parameter int unsigned NUM_STAGES      = 7,
  parameter int unsigned BFLY_PER_STAGE  = 8,
  parameter int unsigned WORDS_PER_STAGE = 4,
  parameter int unsigned ADDR_W          = 5,
  parameter int unsigned DATA_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] tw_data,
  output logic [2:0]        tw_stage,
  output logic [2:0]        tw_bfly,
  output logic              tw_valid,
  input  logic              tw_ready,
  output logic              stage_done
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam logic [2:0] LastStage = 3'(NUM_STAGES - 1);
  localparam logic [2:0] LastBfly  = 3'(BFLY_PER_STAGE - 1);

  state_e              state_q;
  logic                busy_q, done_q;
  logic [2:0]          stage_q, bfly_q;
  logic [ADDR_W-1:0]   rom_addr_q;
  // Address stage: tags of the word whose address is currently on rom_addr.
  logic                a_valid_q;
  logic [2:0]          a_stage_q, a_bfly_q;
  // Data stage: tags of the word currently on rom_data (or captured in p1_data_q).
  logic                p1_valid_q, p1_held_q;
  logic [2:0]          p1_stage_q, p1_bfly_q;
  logic [DATA_W-1:0]   p1_data_q;
  logic                tw_valid_q;
  logic [DATA_W-1:0]   tw_data_q;
  logic [2:0]          tw_stage_q, tw_bfly_q;

  logic                stall, last_issue, final_accept;
  logic [31:0]         issue_addr_full;
  logic [DATA_W-1:0]   p1_src;

  always_comb begin
    stall           = tw_valid_q & ~tw_ready;
    last_issue      = (stage_q == LastStage) && (bfly_q == LastBfly);
    final_accept    = tw_valid_q & tw_ready & (tw_stage_q == LastStage) & (tw_bfly_q == LastBfly);
    issue_addr_full = 32'(stage_q) * WORDS_PER_STAGE + (32'(bfly_q) % WORDS_PER_STAGE);
    // While stalled the ROM re-reads the held address, so the data-stage word is kept locally.
    p1_src          = p1_held_q ? p1_data_q : rom_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      stage_q    <= '0;
      bfly_q     <= '0;
      rom_addr_q <= '0;
      a_valid_q  <= 1'b0;
      a_stage_q  <= '0;
      a_bfly_q   <= '0;
      p1_valid_q <= 1'b0;
      p1_held_q  <= 1'b0;
      p1_stage_q <= '0;
      p1_bfly_q  <= '0;
      p1_data_q  <= '0;
      tw_valid_q <= 1'b0;
      tw_data_q  <= '0;
      tw_stage_q <= '0;
      tw_bfly_q  <= '0;
    end else if (abort && (state_q != StIdle)) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      stage_q    <= '0;
      bfly_q     <= '0;
      a_valid_q  <= 1'b0;
      p1_valid_q <= 1'b0;
      p1_held_q  <= 1'b0;
      tw_valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (!stall) begin
        a_valid_q  <= 1'b0;
        p1_valid_q <= a_valid_q;
        p1_stage_q <= a_stage_q;
        p1_bfly_q  <= a_bfly_q;
        p1_held_q  <= 1'b0;
        tw_valid_q <= p1_valid_q;
        if (p1_valid_q) begin
          tw_data_q  <= p1_src;
          tw_stage_q <= p1_stage_q;
          tw_bfly_q  <= p1_bfly_q;
        end
      end else if (!p1_held_q) begin
        p1_data_q <= rom_data;
        p1_held_q <= 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRun;
            busy_q  <= 1'b1;
            stage_q <= '0;
            bfly_q  <= '0;
          end
        end
        StRun: begin
          if (!stall) begin
            a_valid_q  <= 1'b1;
            a_stage_q  <= stage_q;
            a_bfly_q   <= bfly_q;
            rom_addr_q <= issue_addr_full[ADDR_W-1:0];
            if (last_issue) begin
              state_q <= StDrain;
            end else if (bfly_q == LastBfly) begin
              bfly_q  <= '0;
              stage_q <= stage_q + 3'd1;
            end else begin
              bfly_q <= bfly_q + 3'd1;
            end
          end
        end
        StDrain: begin
          if (final_accept) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rom_addr   = rom_addr_q;
  assign tw_data    = tw_data_q;
  assign tw_stage   = tw_stage_q;
  assign tw_bfly    = tw_bfly_q;
  assign tw_valid   = tw_valid_q;
  assign stage_done = tw_valid_q & tw_ready & (tw_bfly_q == LastBfly);

endmodule

// File: tb/tb_ifft_twiddle_sequencer.sv
// Bench for ifft_twiddle_sequencer: registered ROM model, beat monitor and a per-frame
// expected stream computed from the stage/butterfly address rule.
module tb_ifft_twiddle_sequencer;

  localparam int NBEATS = 56;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, tw_ready;
  logic        busy, done, tw_valid, stage_done;
  logic [4:0]  rom_addr;
  logic [15:0] rom_data, tw_data;
  logic [2:0]  tw_stage, tw_bfly;

  ifft_twiddle_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .tw_data    (tw_data),
    .tw_stage   (tw_stage),
    .tw_bfly    (tw_bfly),
    .tw_valid   (tw_valid),
    .tw_ready   (tw_ready),
    .stage_done (stage_done)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [32];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected beat stream for one full frame.
  logic [4:0]  exp_addr  [NBEATS];
  logic [15:0] exp_data  [NBEATS];
  logic [2:0]  exp_stage [NBEATS];
  logic [2:0]  exp_bfly  [NBEATS];

  logic [15:0] q_data [$];
  logic [2:0]  q_stage [$];
  logic [2:0]  q_bfly [$];
  int          q_cyc [$];
  int          sd_cnt, done_cnt, stall_err;
  bit          prev_stall = 0;
  logic [4:0]  prev_addr;

  always @(negedge clk) begin
    if (rst_n && tw_valid && tw_ready) begin
      q_data.push_back(tw_data);
      q_stage.push_back(tw_stage);
      q_bfly.push_back(tw_bfly);
      q_cyc.push_back(cyc);
    end
    if (stage_done) sd_cnt++;
    if (done) done_cnt++;
    if (rst_n && prev_stall && rom_addr !== prev_addr) stall_err++;
    prev_stall = rst_n && tw_valid && !tw_ready;
    prev_addr  = rom_addr;
  end

  task automatic clear_mon();
    q_data.delete(); q_stage.delete(); q_bfly.delete(); q_cyc.delete();
    sd_cnt = 0; done_cnt = 0; stall_err = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic build_model();
    for (int i = 0; i < 32; i++) rom[i] = 16'($urandom_range(0, 255));
    rom[21] = 16'h00FE;
    rom[9]  = 16'h00B5;
    rom[27] = 16'h00CD;
    for (int s = 0; s < 7; s++) begin
      for (int b = 0; b < 8; b++) begin
        exp_addr[s*8+b]  = 5'((s * 4 + b % 4) % 32);
        exp_data[s*8+b]  = rom[(s * 4 + b % 4) % 32];
        exp_stage[s*8+b] = 3'(s);
        exp_bfly[s*8+b]  = 3'(b);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; tw_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (tw_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", tw_valid); end
    total++; if (rom_addr !== 5'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", rom_addr); end
    total++; if (done !== 1'b0)     begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_sequence();
    int first_valid = -1, done_c = -1;
    @(posedge clk); #1;
    tw_ready = 1'b1;
    clear_mon();
    pulse_start();
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= NBEATS) begin
        total++;
        if (rom_addr !== exp_addr[c-1]) begin
          bad++; $display("FAIL addr_seq c=%0d got=%0d want=%0d", c, rom_addr, exp_addr[c-1]);
        end
      end
      if (tw_valid && first_valid < 0) first_valid = c;
      if (done && done_c < 0) done_c = c;
      if (c == 58) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_before_done got=%b want=1", busy); end
      end
    end
    total++; if (first_valid != 3) begin bad++; $display("FAIL first_valid got=%0d want=3", first_valid); end
    total++; if (done_c != 59)     begin bad++; $display("FAIL done_cycle got=%0d want=59", done_c); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL busy_after got=%b want=0", busy); end
    total++; if (sd_cnt != 7)      begin bad++; $display("FAIL stage_done_cnt got=%0d want=7", sd_cnt); end
    total++; if (done_cnt != 1)    begin bad++; $display("FAIL done_cnt got=%0d want=1", done_cnt); end
    total++;
    if (q_data.size() != NBEATS) begin
      bad++; $display("FAIL seq_beats got=%0d want=%0d", q_data.size(), NBEATS);
    end else begin
      for (int i = 0; i < NBEATS; i++) begin
        total++;
        if (q_data[i] !== exp_data[i] || q_stage[i] !== exp_stage[i] || q_bfly[i] !== exp_bfly[i]) begin
          bad++; $display("FAIL seq_beat i=%0d got=%h/%0d/%0d want=%h/%0d/%0d", i, q_data[i],
                          q_stage[i], q_bfly[i], exp_data[i], exp_stage[i], exp_bfly[i]);
        end
      end
      total++; if (q_cyc[NBEATS-1] - q_cyc[0] != NBEATS - 1) begin
        bad++; $display("FAIL contiguous span got=%0d want=%0d", q_cyc[NBEATS-1] - q_cyc[0], NBEATS - 1);
      end
      total++; if (q_data[41] !== 16'h00FE || q_stage[41] !== 3'd5 || q_bfly[41] !== 3'd1) begin
        bad++; $display("FAIL beat_s5b1 got=%h/%0d/%0d want=00fe/5/1", q_data[41], q_stage[41], q_bfly[41]);
      end
      total++; if (q_data[17] !== 16'h00B5 || q_stage[17] !== 3'd2 || q_bfly[17] !== 3'd1) begin
        bad++; $display("FAIL beat_s2b1 got=%h/%0d/%0d want=00b5/2/1", q_data[17], q_stage[17], q_bfly[17]);
      end
      total++; if (q_data[51] !== 16'h00CD || q_stage[51] !== 3'd6 || q_bfly[51] !== 3'd3) begin
        bad++; $display("FAIL beat_s6b3 got=%h/%0d/%0d want=00cd/6/3", q_data[51], q_stage[51], q_bfly[51]);
      end
    end
  endtask

  task automatic test_random_stall();
    int n = 0;
    @(posedge clk); #1;
    clear_mon();
    pulse_start();
    while (done_cnt == 0 && n < 2000) begin
      tw_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    tw_ready = 1'b1;
    total++; if (done_cnt == 0) begin bad++; $display("FAIL stall_timeout got=no_done want=done"); end
    repeat (5) @(posedge clk);
    #1;
    total++; if (stall_err != 0) begin bad++; $display("FAIL stall_addr_moved got=%0d want=0", stall_err); end
    total++; if (sd_cnt != 7)    begin bad++; $display("FAIL stall_stage_done got=%0d want=7", sd_cnt); end
    total++;
    if (q_data.size() != NBEATS) begin
      bad++; $display("FAIL stall_beats got=%0d want=%0d", q_data.size(), NBEATS);
    end else begin
      for (int i = 0; i < NBEATS; i++) begin
        total++;
        if (q_data[i] !== exp_data[i] || q_stage[i] !== exp_stage[i] || q_bfly[i] !== exp_bfly[i]) begin
          bad++; $display("FAIL stall_beat i=%0d got=%h/%0d/%0d want=%h/%0d/%0d", i, q_data[i],
                          q_stage[i], q_bfly[i], exp_data[i], exp_stage[i], exp_bfly[i]);
        end
      end
    end
  endtask

  task automatic test_abort();
    int n = 0, held;
    @(posedge clk); #1;
    tw_ready = 1'b1;
    clear_mon();
    pulse_start();
    while (q_data.size() < 20 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    total++; if (tw_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b want=0", tw_valid); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    held = q_data.size();
    repeat (10) @(posedge clk);
    #1;
    total++; if (done_cnt != 0)        begin bad++; $display("FAIL abort_done got=%0d want=0", done_cnt); end
    total++; if (q_data.size() != held) begin bad++; $display("FAIL abort_extra got=%0d want=%0d", q_data.size(), held); end
    clear_mon();
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    total++; if (rom_addr !== 5'd0) begin bad++; $display("FAIL restart_addr got=%0d want=0", rom_addr); end
    repeat (70) @(posedge clk);
    #1;
    total++; if (done_cnt != 1) begin bad++; $display("FAIL restart_done got=%0d want=1", done_cnt); end
    total++;
    if (q_data.size() != NBEATS) begin
      bad++; $display("FAIL restart_beats got=%0d want=%0d", q_data.size(), NBEATS);
    end else if (q_data[0] !== exp_data[0] || q_stage[0] !== 3'd0 || q_bfly[0] !== 3'd0) begin
      bad++; $display("FAIL restart_first got=%h/%0d/%0d want=%h/0/0", q_data[0], q_stage[0], q_bfly[0], exp_data[0]);
    end
  endtask

  task automatic test_extra_start();
    int n = 0;
    @(posedge clk); #1;
    tw_ready = 1'b1;
    clear_mon();
    pulse_start();
    repeat (10) @(posedge clk);
    #1;
    pulse_start();
    while (!done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    total++; if (!done) begin bad++; $display("FAIL extra_timeout got=no_done want=done"); end
    pulse_start();
    repeat (10) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0)          begin bad++; $display("FAIL extra_busy got=%b want=0", busy); end
    total++; if (done_cnt != 1)          begin bad++; $display("FAIL extra_done got=%0d want=1", done_cnt); end
    total++; if (q_data.size() != NBEATS) begin bad++; $display("FAIL extra_beats got=%0d want=%0d", q_data.size(), NBEATS); end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    tw_ready = 1'b1;
    clear_mon();
    pulse_start();
    repeat (30) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL areset_busy got=%b want=0", busy); end
    total++; if (tw_valid !== 1'b0)   begin bad++; $display("FAIL areset_valid got=%b want=0", tw_valid); end
    total++; if (stage_done !== 1'b0) begin bad++; $display("FAIL areset_sd got=%b want=0", stage_done); end
    total++; if (rom_addr !== 5'd0)   begin bad++; $display("FAIL areset_addr got=%0d want=0", rom_addr); end
    total++; if (tw_data !== 16'd0)   begin bad++; $display("FAIL areset_data got=%h want=0", tw_data); end
    total++; if (tw_stage !== 3'd0 || tw_bfly !== 3'd0) begin
      bad++; $display("FAIL areset_tags got=%0d/%0d want=0/0", tw_stage, tw_bfly);
    end
    #3 rst_n = 1'b1;
    clear_mon();
    repeat (10) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0 || tw_valid !== 1'b0) begin
      bad++; $display("FAIL post_reset_idle got=%b/%b want=0/0", busy, tw_valid);
    end
    total++; if (q_data.size() != 0) begin bad++; $display("FAIL post_reset_beats got=%0d want=0", q_data.size()); end
  endtask

  initial begin
    build_model();
    test_reset();
    test_sequence();
    test_random_stall();
    test_abort();
    test_extra_start();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
